// File: rtl/hazard_ctrl.sv
// Stall/bubble controller for a non-forwarding five-stage pipeline: scoreboard of in-flight rd.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned REG_AW     = 5
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_id_valid,
   input  logic [REG_AW-1:0]        i_id_rs1_addr,
   input  logic [REG_AW-1:0]        i_id_rs2_addr,
   input  logic                     i_id_rs1_used,
   input  logic                     i_id_rs2_used,
   input  logic [REG_AW-1:0]        i_id_rd_addr,
   input  logic                     i_id_rd_wren,
   input  logic                     i_flush,
   output logic                     o_stall,
   output logic                     o_id_bubble,
   output logic [(2**REG_AW)-1:0]   o_pending,
   output logic [31:0]              o_stall_cycles
);

   localparam int unsigned NREGS = 2**REG_AW;

   // Entry 0 is EX, entry NUM_STAGES-1 is WB.
   logic [NUM_STAGES-1:0]             sb_valid_q;
   logic [NUM_STAGES-1:0][REG_AW-1:0] sb_rd_q;

   logic              rs1_match;
   logic              rs2_match;
   logic              hz1;
   logic              hz2;
   logic              hazard;
   logic              issue;
   logic              push_valid;
   logic [REG_AW-1:0] push_rd;
   logic [NREGS-1:0]  pending;

   always_comb begin
      rs1_match = 1'b0;
      rs2_match = 1'b0;
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
         if (sb_valid_q[i] && (sb_rd_q[i] == i_id_rs1_addr)) rs1_match = 1'b1;
         if (sb_valid_q[i] && (sb_rd_q[i] == i_id_rs2_addr)) rs2_match = 1'b1;
      end
   end

   // No write-through in the register file, so a WB match still counts.
   assign hz1    = i_id_rs1_used & (i_id_rs1_addr != '0) & rs1_match;
   assign hz2    = i_id_rs2_used & (i_id_rs2_addr != '0) & rs2_match;
   assign hazard = i_id_valid & (hz1 | hz2);

   assign o_stall     = hazard & ~i_flush;
   assign o_id_bubble = o_stall | i_flush;

   assign issue      = i_id_valid & ~o_stall & ~i_flush;
   assign push_valid = issue & i_id_rd_wren & (i_id_rd_addr != '0);
   assign push_rd    = issue ? i_id_rd_addr : '0;

   always_comb begin
      pending = '0;
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
         if (sb_valid_q[i]) pending[sb_rd_q[i]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

   assign o_pending = pending;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sb_valid_q <= '0;
         sb_rd_q    <= '0;
      end else begin
         for (int i = int'(NUM_STAGES) - 1; i > 0; i--) begin
            sb_valid_q[i] <= sb_valid_q[i-1];
            sb_rd_q[i]    <= sb_rd_q[i-1];
         end
         sb_valid_q[0] <= push_valid;
         sb_rd_q[0]    <= push_rd;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_q <= '0;
      end else if (o_stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign o_stall_cycles = stall_cnt_q;
`else
   assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-register pending-lifetime model plus directed scenarios.
module tb_hazard_ctrl;

   localparam int unsigned NUM_STAGES = 3;
   localparam int unsigned REG_AW     = 5;
   localparam int unsigned NREGS      = 2**REG_AW;

   logic              clk;
   logic              rst_n;
   logic              id_valid;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic              rs1_used;
   logic              rs2_used;
   logic [REG_AW-1:0] rd;
   logic              rd_wren;
   logic              flush;
   logic              stall;
   logic              bubble;
   logic [NREGS-1:0]  pending;
   logic [31:0]       stall_cycles;

   int n_total = 0;
   int n_pass  = 0;

   hazard_ctrl #(
      .NUM_STAGES (NUM_STAGES),
      .REG_AW     (REG_AW)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_id_valid     (id_valid),
      .i_id_rs1_addr  (rs1),
      .i_id_rs2_addr  (rs2),
      .i_id_rs1_used  (rs1_used),
      .i_id_rs2_used  (rs2_used),
      .i_id_rd_addr   (rd),
      .i_id_rd_wren   (rd_wren),
      .i_flush        (flush),
      .o_stall        (stall),
      .o_id_bubble    (bubble),
      .o_pending      (pending),
      .o_stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a register stays pending for NUM_STAGES cycles after its latest producer issues.
   int          rem [NREGS];
   logic [31:0] exp_cnt;

   function automatic logic model_stall();
      logic h1, h2;
      h1 = rs1_used && (rs1 != 0) && (rem[rs1] > 0);
      h2 = rs2_used && (rs2 != 0) && (rem[rs2] > 0);
      return id_valid && (h1 || h2) && !flush;
   endfunction

   function automatic logic [NREGS-1:0] model_pending();
      logic [NREGS-1:0] p;
      p = '0;
      for (int r = 1; r < int'(NREGS); r++) p[r] = (rem[r] > 0);
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(NREGS); r++) rem[r] = 0;
         exp_cnt = '0;
      end else begin
         logic st;
         st = model_stall();
         for (int r = 0; r < int'(NREGS); r++) if (rem[r] > 0) rem[r] = rem[r] - 1;
         if (id_valid && !st && !flush && rd_wren && (rd != 0)) rem[rd] = NUM_STAGES;
`ifdef HAZARD_PERF_EN
         if (st && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
`endif
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("stall", stall, model_stall());
         check("bubble", bubble, model_stall() | flush);
         check("pending", pending, model_pending());
         check("stall_cycles", stall_cycles, exp_cnt);
      end
   end

   task automatic idle(input int n);
      id_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
      rd = 0; rd_wren = 0; flush = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present an instruction and hold it until it issues; returns the number of stall cycles.
   task automatic present(input logic [REG_AW-1:0] a1, input logic u1,
                          input logic [REG_AW-1:0] a2, input logic u2,
                          input logic [REG_AW-1:0] d, input logic w, output int stalls);
      id_valid = 1; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
      rd = d; rd_wren = w; flush = 0;
      stalls = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!stall) break;
         stalls++;
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
   endtask

   int s;

   initial begin
      // Reset with a would-be hazard on the inputs.
      rst_n = 0;
      idle(0);
      id_valid = 1; rs1 = 5; rs1_used = 1;
      #3;
      check("reset_stall", stall, 1'b0);
      check("reset_pending", pending, '0);
      check("reset_cycles", stall_cycles, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      idle(2);

      // Back-to-back RAW.
      present(0, 0, 0, 0, 5, 1, s);
      check("raw_producer_stall", s, 0);
      present(5, 1, 0, 0, 0, 0, s);
      check("raw_stalls", s, 3);
`ifdef HAZARD_PERF_EN
      check("raw_perf_cycles", stall_cycles, 32'd3);
`endif
      idle(4);

      // x0 producer never pends.
      present(0, 0, 0, 0, 0, 1, s);
      present(0, 1, 0, 0, 0, 0, s);
      check("x0_stalls", s, 0);
      @(negedge clk);
      check("x0_pending", pending, '0);
      @(posedge clk); #1;
      idle(4);

      // Unused operand B.
      present(0, 0, 0, 0, 7, 1, s);
      present(0, 0, 7, 0, 0, 0, s);
      check("unused_rs2_stalls", s, 0);
      idle(4);

      // Producer/consumer distance with n independent instructions in between.
      for (int n = 1; n <= 3; n++) begin
         present(0, 0, 0, 0, 9, 1, s);
         for (int j = 0; j < n; j++) present(0, 0, 0, 0, 0, 0, s);
         present(0, 0, 9, 1, 0, 0, s);
         check($sformatf("distance_%0d_stalls", n), s, 3 - n);
         idle(4);
      end

      // Flush in the second stall cycle.
      present(0, 0, 0, 0, 5, 1, s);
      id_valid = 1; rs1 = 5; rs1_used = 1; rd = 0; rd_wren = 0;
      @(negedge clk);
      check("flush_first_stall", stall, 1'b1);
      @(posedge clk); #1 flush = 1;
      @(negedge clk);
      check("flush_stall", stall, 1'b0);
      check("flush_bubble", bubble, 1'b1);
      @(posedge clk); #1 idle(0);
      @(negedge clk);
      check("flush_pending_still", pending[5], 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("flush_pending_cleared", pending[5], 1'b0);
      @(posedge clk); #1;
      idle(3);

      // Reset asserted mid-stall.
      present(0, 0, 0, 0, 6, 1, s);
      id_valid = 1; rs1 = 6; rs1_used = 1;
      @(negedge clk);
      check("midreset_before", stall, 1'b1);
      #2 rst_n = 0;
      #1;
      check("midreset_pending", pending, '0);
      check("midreset_stall", stall, 1'b0);
      check("midreset_cycles", stall_cycles, 32'd0);
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      check("after_release_stall", stall, 1'b0);
      @(posedge clk); #1;
      idle(4);

      // Randomized traffic over a small register range to provoke frequent hits.
      for (int c = 0; c < 600; c++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         rs1      = REG_AW'($urandom_range(0, 7));
         rs2      = REG_AW'($urandom_range(0, 7));
         rs1_used = 1'($urandom_range(0, 1));
         rs2_used = 1'($urandom_range(0, 1));
         rd       = REG_AW'($urandom_range(0, 7));
         rd_wren  = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 9) == 0);
         @(posedge clk);
         #1;
      end
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
